hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline hazard and sequencing controller for the 5-stage RV32 core. Each cycle it decides whether the IF/ID/EX pipeline registers stall, flush or advance. It also generates EX-stage forwarding selects. It runs a start/done handshake with the multicycle M-extension unit (mul/div) and keeps saturating stall/flush performance counters. It sits beside the IF/ID, ID/EX, EX/MEM registers and drives their enable/clear inputs.

## Interface
- `MD_TIMEOUT`, default 64: maximum number of BUSY cycles waited for `md_done` before a forced release.
- `CNT_WIDTH`, default 32: width of each performance counter.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `D_Rs1`, `D_Rs2`, in, 5 each: source registers of the instruction in decode.
- `E_Rs1`, `E_Rs2`, `E_Rd`, in, 5 each: register fields of the instruction in execute.
- `E_ResultSrc`, in, 2: value 2'b01 marks the EX instruction as a load.
- `E_PCSrc`, in, 1: branch taken or jump, resolved in EX.
- `E_MulDiv`, in, 1: the EX instruction needs the multicycle M unit.
- `M_Rd`, `W_Rd`, in, 5 each; `M_RegWrite`, `W_RegWrite`, in, 1 each: writeback info for forwarding.
- `md_done`, in, 1: one-cycle result-valid pulse from the M unit.
- `F_Stall`, `D_Stall`, `E_Stall`, out, 1 each: hold the PC, IF/ID and ID/EX registers.
- `D_Flush`, `E_Flush`, `M_Flush`, out, 1 each: synchronous clear of IF/ID, ID/EX and EX/MEM (bubble insert).
- `E_ForwardA`, `E_ForwardB`, out, 2 each: 00 register file, 10 MEM ALU result, 01 WB result.
- `md_start`, out, 1: one-cycle start pulse to the M unit.
- `md_timeout`, out, 1: sticky error flag.
- `stall_cycles`, `flush_events`, out, `CNT_WIDTH` each: performance counters.

## Operation
- FSM states:
  - RUN (reset state).
  - BUSY (M unit operating).
- RUN → BUSY when `E_MulDiv`=1.
  - `md_start`=1 that cycle only.
  - The BUSY cycle counter `bcnt` clears to 0.
- BUSY → RUN on `md_done`=1, or when `bcnt`=`MD_TIMEOUT`-1 without `md_done` (forced release).
  - A forced release sets `md_timeout`. It stays set until reset.
- In BUSY, `bcnt` increments each cycle.
- `md_done` in RUN is ignored.
- `mdStall` = (RUN & `E_MulDiv`) | (BUSY & ~release), where release = `md_done` | timeout.
- `lwStall` = (`E_ResultSrc`=2'b01) & (`E_Rd`≠0) & (`E_Rd`=`D_Rs1` | `E_Rd`=`D_Rs2`).
- `F_Stall` = `D_Stall` = `lwStall` | `mdStall`.
- `E_Stall` = `mdStall`. `M_Flush` = `mdStall`.
- `D_Flush` = `E_PCSrc`.
- `E_Flush` = `lwStall` | `E_PCSrc`.
- If `E_PCSrc` and `lwStall` are both 1, the branch wins: F/D stall is still asserted, and the flushes clear the wrong-path instruction.
- Forwarding for operand A (B identical with `E_Rs2`), in priority order:
  - 10 if `M_RegWrite` & `M_Rd`≠0 & `M_Rd`=`E_Rs1`.
  - else 01 if `W_RegWrite` & `W_Rd`≠0 & `W_Rd`=`E_Rs1`.
  - else 00.
- `stall_cycles` increments on each cycle with `F_Stall`=1.
- `flush_events` increments on each cycle with `E_Flush`=1.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset (async assert, sync release to the clock):
  - state=RUN, `bcnt`=0, `md_timeout`=0, both counters 0.
  - While `rst_n`=0, every stall, flush and `md_start` output is forced to 0, and forward selects are 00.
- All stall, flush and forward outputs are combinational from inputs and state, valid in the same cycle, with zero latency.
- M handshake:
  - `md_start` at cycle 0; `md_done` at cycle k≥1.
  - Stalls and `M_Flush` are asserted in cycles 0..k-1 and released in cycle k, so ID/EX and EX/MEM advance at the end of cycle k.
  - The front end freezes for exactly k cycles.
- Back-to-back mul/div: the next `E_MulDiv` is seen in RUN in cycle k+1. `md_start` re-pulses with no idle gap beyond that cycle.
- Timeout: the forced release happens in the cycle where `bcnt`=`MD_TIMEOUT`-1. `md_timeout` reads 1 from the next cycle.
- A late `md_done` after a timeout release is ignored, because the FSM is in RUN.
- Reset in BUSY: the FSM returns to RUN immediately and stalls drop asynchronously.

## Test plan
- Load-use hazard:
  - Stimulus: `E_ResultSrc`=01, `E_Rd`=5, `D_Rs2`=5.
  - Required: `F_Stall`=`D_Stall`=`E_Flush`=1 for 1 cycle, `stall_cycles`=1, `flush_events`=1.
  - Same with `E_Rd`=0: no stall.
- Forwarding:
  - Stimulus: `E_Rs1`=3, `M_Rd`=`W_Rd`=3, both RegWrite=1.
  - Required: `E_ForwardA`=10.
  - Then drop `M_RegWrite`: `E_ForwardA`=01. `E_Rs1`=0: 00.
- Branch flush:
  - Stimulus: `E_PCSrc`=1 together with a `lwStall` condition.
  - Required: `D_Flush`=`E_Flush`=1, stall also 1. `flush_events` increments by 1.
- M unit with `md_done` 5 cycles after start:
  - Required: `md_start` pulses once.
  - `F_Stall`/`E_Stall`/`M_Flush`=1 for exactly 5 cycles, 0 on the done cycle.
  - A back-to-back second mul/div restarts in the next cycle.
- Timeout with `MD_TIMEOUT`=8 and `md_done` never asserted:
  - Required: release in the 8th BUSY cycle.
  - `md_timeout`=1 afterwards, and it stays 1.
  - A late `md_done` has no effect.
- Reset mid-BUSY:
  - Stimulus: pull `rst_n` low during cycle 3 of a mul/div.
  - Required: all outputs 0/00 immediately, and `md_timeout`=0 and counters=0.
  - After release the FSM is in RUN.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Pipeline hazard and sequencing controller for the 5-stage RV32 core: stall/flush
// control, EX forwarding selects, M-unit start/done handshake and perf counters.
module hazard_scheduler #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           D_Rs1,
  input  logic [4:0]           D_Rs2,
  input  logic [4:0]           E_Rs1,
  input  logic [4:0]           E_Rs2,
  input  logic [4:0]           E_Rd,
  input  logic [1:0]           E_ResultSrc,
  input  logic                 E_PCSrc,
  input  logic                 E_MulDiv,
  input  logic [4:0]           M_Rd,
  input  logic [4:0]           W_Rd,
  input  logic                 M_RegWrite,
  input  logic                 W_RegWrite,
  input  logic                 md_done,
  output logic                 F_Stall,
  output logic                 D_Stall,
  output logic                 E_Stall,
  output logic                 D_Flush,
  output logic                 E_Flush,
  output logic                 M_Flush,
  output logic [1:0]           E_ForwardA,
  output logic [1:0]           E_ForwardB,
  output logic                 md_start,
  output logic                 md_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int unsigned   BW   = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [BW-1:0] LAST = BW'(MD_TIMEOUT - 1);

  logic [0:0]    state;
  logic [BW-1:0] bcnt;
  logic          lw_stall;
  logic          timeout_hit;
  logic          md_release;
  logic          md_stall;

  always_comb begin
    lw_stall    = (E_ResultSrc == 2'b01) && (E_Rd != '0) &&
                  ((E_Rd == D_Rs1) || (E_Rd == D_Rs2));
    // A done pulse in the last allowed cycle is a normal release, not a timeout.
    timeout_hit = (state == BUSY) && !md_done && (bcnt == LAST);
    md_release  = md_done || timeout_hit;
    md_stall    = ((state == RUN) && E_MulDiv) || ((state == BUSY) && !md_release);

    F_Stall  = rst_n && (lw_stall || md_stall);
    D_Stall  = rst_n && (lw_stall || md_stall);
    E_Stall  = rst_n && md_stall;
    M_Flush  = rst_n && md_stall;
    D_Flush  = rst_n && E_PCSrc;
    E_Flush  = rst_n && (lw_stall || E_PCSrc);
    md_start = rst_n && (state == RUN) && E_MulDiv;

    E_ForwardA = 2'b00;
    if (rst_n) begin
      if (M_RegWrite && (M_Rd != '0) && (M_Rd == E_Rs1))      E_ForwardA = 2'b10;
      else if (W_RegWrite && (W_Rd != '0) && (W_Rd == E_Rs1)) E_ForwardA = 2'b01;
    end

    E_ForwardB = 2'b00;
    if (rst_n) begin
      if (M_RegWrite && (M_Rd != '0) && (M_Rd == E_Rs2))      E_ForwardB = 2'b10;
      else if (W_RegWrite && (W_Rd != '0) && (W_Rd == E_Rs2)) E_ForwardB = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      bcnt       <= '0;
      md_timeout <= 1'b0;
    end else begin
      if (timeout_hit) md_timeout <= 1'b1;
      case (state)
        RUN: begin
          if (E_MulDiv) begin
            state <= BUSY;
            bcnt  <= '0;
          end
        end
        default: begin
          if (md_release) state <= RUN;
          else            bcnt  <= bcnt + BW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (F_Stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (E_Flush && (flush_events != '1)) flush_events <= flush_events + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with MD_TIMEOUT=8 and 8-bit counters.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd;
  logic [1:0] E_ResultSrc;
  logic       E_PCSrc, E_MulDiv, M_RegWrite, W_RegWrite, md_done;
  logic       F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, md_start, md_timeout;
  logic [1:0] E_ForwardA, E_ForwardB;
  logic [7:0] stall_cycles, flush_events;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  // ctl = {F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, md_start}
  assign ctl = {F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, md_start};

  hazard_scheduler #(.MD_TIMEOUT(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .E_Rs1(E_Rs1), .E_Rs2(E_Rs2), .E_Rd(E_Rd),
    .E_ResultSrc(E_ResultSrc), .E_PCSrc(E_PCSrc), .E_MulDiv(E_MulDiv),
    .M_Rd(M_Rd), .W_Rd(W_Rd), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
    .md_done(md_done),
    .F_Stall(F_Stall), .D_Stall(D_Stall), .E_Stall(E_Stall),
    .D_Flush(D_Flush), .E_Flush(E_Flush), .M_Flush(M_Flush),
    .E_ForwardA(E_ForwardA), .E_ForwardB(E_ForwardB),
    .md_start(md_start), .md_timeout(md_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    D_Rs1 = '0; D_Rs2 = '0; E_Rs1 = '0; E_Rs2 = '0; E_Rd = '0; M_Rd = '0; W_Rd = '0;
    E_ResultSrc = 2'b00; E_PCSrc = 1'b0; E_MulDiv = 1'b0;
    M_RegWrite = 1'b0; W_RegWrite = 1'b0; md_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    E_ResultSrc = 2'b01; E_Rd = 5'd5; D_Rs1 = 5'd5; E_PCSrc = 1'b1; E_MulDiv = 1'b1;
    E_Rs1 = 5'd3; M_Rd = 5'd3; M_RegWrite = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 7'b0); end
    checks++;
    if ({E_ForwardA, E_ForwardB} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd got %b exp 0000", {E_ForwardA, E_ForwardB});
    end
    checks++;
    if ({md_timeout, stall_cycles, flush_events} !== 17'd0) begin
      errors++; $display("FAIL reset_state got to=%b sc=%0d fe=%0d exp 0/0/0",
                         md_timeout, stall_cycles, flush_events);
    end
    repeat (2) @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    E_ResultSrc = 2'b01; E_Rd = 5'd5; D_Rs2 = 5'd5;
    #1;
    checks++;
    if (ctl !== 7'b1100100) begin errors++; $display("FAIL lw_ctl got %b exp %b", ctl, 7'b1100100); end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL lw_one_cycle got %b exp 0", ctl); end
    checks++;
    if ({stall_cycles, flush_events} !== {8'd1, 8'd1}) begin
      errors++; $display("FAIL lw_counters got sc=%0d fe=%0d exp 1/1", stall_cycles, flush_events);
    end
    E_ResultSrc = 2'b01; E_Rd = 5'd0; D_Rs1 = 5'd0; D_Rs2 = 5'd0;
    #1;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL lw_x0 got %b exp 0", ctl); end
    tick();
    clear_inputs();
    checks++;
    if ({stall_cycles, flush_events} !== {8'd1, 8'd1}) begin
      errors++; $display("FAIL lw_x0_counters got sc=%0d fe=%0d exp 1/1", stall_cycles, flush_events);
    end
  endtask

  task automatic test_forwarding();
    E_Rs1 = 5'd3; M_Rd = 5'd3; W_Rd = 5'd3; M_RegWrite = 1'b1; W_RegWrite = 1'b1;
    #1;
    checks++;
    if (E_ForwardA !== 2'b10) begin errors++; $display("FAIL fwdA_mem got %b exp 10", E_ForwardA); end
    checks++;
    if (E_ForwardB !== 2'b00) begin errors++; $display("FAIL fwdB_none got %b exp 00", E_ForwardB); end
    M_RegWrite = 1'b0;
    #1;
    checks++;
    if (E_ForwardA !== 2'b01) begin errors++; $display("FAIL fwdA_wb got %b exp 01", E_ForwardA); end
    E_Rs1 = 5'd0;
    #1;
    checks++;
    if (E_ForwardA !== 2'b00) begin errors++; $display("FAIL fwdA_rf got %b exp 00", E_ForwardA); end
    E_Rs2 = 5'd0; M_Rd = 5'd0; W_Rd = 5'd0; M_RegWrite = 1'b1;
    #1;
    checks++;
    if ({E_ForwardA, E_ForwardB} !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0 got %b exp 0000", {E_ForwardA, E_ForwardB});
    end
    E_Rs2 = 5'd7; M_Rd = 5'd7; W_Rd = 5'd9; M_RegWrite = 1'b1; W_RegWrite = 1'b1;
    #1;
    checks++;
    if (E_ForwardB !== 2'b10) begin errors++; $display("FAIL fwdB_mem got %b exp 10", E_ForwardB); end
    M_Rd = 5'd4; W_Rd = 5'd7;
    #1;
    checks++;
    if (E_ForwardB !== 2'b01) begin errors++; $display("FAIL fwdB_wb got %b exp 01", E_ForwardB); end
    clear_inputs();
  endtask

  task automatic test_branch();
    E_PCSrc = 1'b1; E_ResultSrc = 2'b01; E_Rd = 5'd6; D_Rs1 = 5'd6;
    #1;
    checks++;
    if (ctl !== 7'b1101100) begin errors++; $display("FAIL branch_ctl got %b exp %b", ctl, 7'b1101100); end
    tick();
    clear_inputs();
    checks++;
    if ({stall_cycles, flush_events} !== {8'd2, 8'd2}) begin
      errors++; $display("FAIL branch_counters got sc=%0d fe=%0d exp 2/2", stall_cycles, flush_events);
    end
  endtask

  task automatic test_muldiv();
    int starts;
    int k;
    logic [6:0] exp;
    for (int op = 0; op < 2; op++) begin
      k = (op == 0) ? 5 : 2;
      starts = 0;
      E_MulDiv = 1'b1;
      for (int c = 0; c <= k; c++) begin
        md_done = (c == k);
        #1;
        exp = (c == 0) ? 7'b1110011 : (c < k) ? 7'b1110010 : 7'b0000000;
        checks++;
        if (ctl !== exp) begin
          errors++; $display("FAIL md_op%0d_cycle%0d got %b exp %b", op, c, ctl, exp);
        end
        if (md_start) starts++;
        tick();
        md_done = 1'b0;
      end
      checks++;
      if (starts !== 1) begin errors++; $display("FAIL md_op%0d_starts got %0d exp 1", op, starts); end
    end
    E_MulDiv = 1'b0;
    #1;
    checks++;
    if ({stall_cycles, flush_events} !== {8'd9, 8'd2}) begin
      errors++; $display("FAIL md_counters got sc=%0d fe=%0d exp 9/2", stall_cycles, flush_events);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp;
    E_MulDiv = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      #1;
      exp = (c == 0) ? 7'b1110011 : (c < 8) ? 7'b1110010 : 7'b0000000;
      checks++;
      if ({ctl, md_timeout} !== {exp, 1'b0}) begin
        errors++; $display("FAIL to_cycle%0d got %b/%b exp %b/0", c, ctl, md_timeout, exp);
      end
      tick();
    end
    E_MulDiv = 1'b0; md_done = 1'b1;
    #1;
    checks++;
    if ({ctl, md_timeout} !== {7'b0, 1'b1}) begin
      errors++; $display("FAIL to_late_done got %b/%b exp 0000000/1", ctl, md_timeout);
    end
    tick();
    md_done = 1'b0;
    #1;
    checks++;
    if ({ctl, md_timeout} !== {7'b0, 1'b1}) begin
      errors++; $display("FAIL to_sticky got %b/%b exp 0000000/1", ctl, md_timeout);
    end
    checks++;
    if ({stall_cycles, flush_events} !== {8'd17, 8'd2}) begin
      errors++; $display("FAIL to_counters got sc=%0d fe=%0d exp 17/2", stall_cycles, flush_events);
    end
  endtask

  task automatic test_reset_busy();
    E_MulDiv = 1'b1;
    repeat (3) tick();
    #1;
    checks++;
    if ({ctl, stall_cycles} !== {7'b1110010, 8'd20}) begin
      errors++; $display("FAIL rb_before got %b sc=%0d exp 1110010 sc=20", ctl, stall_cycles);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ctl, E_ForwardA, E_ForwardB} !== 11'b0) begin
      errors++; $display("FAIL rb_outputs got %b exp 0", {ctl, E_ForwardA, E_ForwardB});
    end
    checks++;
    if ({md_timeout, stall_cycles, flush_events} !== 17'd0) begin
      errors++; $display("FAIL rb_state got to=%b sc=%0d fe=%0d exp 0/0/0",
                         md_timeout, stall_cycles, flush_events);
    end
    E_MulDiv = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL rb_run_idle got %b exp 0", ctl); end
    E_MulDiv = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b1110011) begin errors++; $display("FAIL rb_restart got %b exp 1110011", ctl); end
    tick();
    md_done = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL rb_done got %b exp 0", ctl); end
    tick();
    clear_inputs();
    checks++;
    if ({stall_cycles, flush_events} !== {8'd1, 8'd0}) begin
      errors++; $display("FAIL rb_counters got sc=%0d fe=%0d exp 1/0", stall_cycles, flush_events);
    end
  endtask

  task automatic test_saturation();
    E_ResultSrc = 2'b01; E_Rd = 5'd8; D_Rs1 = 5'd8;
    repeat (254) tick();
    checks++;
    if ({stall_cycles, flush_events} !== {8'd255, 8'd254}) begin
      errors++; $display("FAIL sat_edge got sc=%0d fe=%0d exp 255/254", stall_cycles, flush_events);
    end
    repeat (46) tick();
    checks++;
    if ({stall_cycles, flush_events, F_Stall} !== {8'd255, 8'd255, 1'b1}) begin
      errors++; $display("FAIL sat_hold got sc=%0d fe=%0d fs=%b exp 255/255/1",
                         stall_cycles, flush_events, F_Stall);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_muldiv();
    test_timeout();
    test_reset_busy();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
